// File: rtl/led_scan_sequencer_pkg.sv
// led_seq_pkg: shared types and constants for the LED scan sequencer
package led_seq_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, OVR} state_t;
  typedef enum logic {UP, DOWN} dir_t;
  localparam logic [1:0] MODE_BLANK  = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;
  localparam logic [2:0] DEC_EN_ON   = 3'b100;
  localparam logic [2:0] DEC_EN_OFF  = 3'b000;
endpackage

// File: rtl/led_scan_sequencer_if.sv
// led_scan_sequencer_if: straps, host override port and decoder drive of the sequencer
//  run/mode      board straps (scan allowed, scan pattern)
//  req_*         host override request, ready is the handshake return
//  switch/enable 3-to-8 decoder select and enable, wrap is the scan wrap pulse
interface led_scan_sequencer_if;
  logic       run;
  logic [1:0] mode;
  logic       req_valid;
  logic [2:0] req_idx;
  logic       req_ready;
  logic [2:0] switch;
  logic [2:0] enable;
  logic       wrap;
  modport master (output run, mode, req_valid, req_idx, input req_ready, switch, enable, wrap);
  modport slave  (input run, mode, req_valid, req_idx, output req_ready, switch, enable, wrap);
endinterface

// File: rtl/led_scan_sequencer_tick.sv
// scan_tick_gen: divides clk by TICK_DIV while enabled, pulses tick on the last count
//  clk, rst_n  clock and async active-low reset
//  en          count this cycle (held otherwise)
//  clr         restart the count at 0
//  tick        combinational, high on the cycle the count reaches TICK_DIV-1 while enabled
module scan_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer: scans one lit LED through a 3-to-8 decoder with a timed host override
//  clk, rst_n  clock and async active-low reset
//  bus         slave side of led_scan_sequencer_if (straps, override request, decoder drive)
module led_scan_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV    = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_scan_sequencer_if.slave   bus
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  state_t        state, state_n;
  dir_t          dir, dir_n;
  logic [2:0]    pos, pos_n, idx, idx_n;
  logic [HW-1:0] hold, hold_n;
  logic          tick, wrap_n, active, hold_done, up_step, bounce;
  assign active        = bus.run && bus.mode != MODE_BLANK;
  assign hold_done     = hold == HW'(HOLD_CYCLES - 1);
  assign bus.req_ready = state != OVR;
  assign bounce        = bus.mode == MODE_BOUNCE;
  assign up_step       = bus.mode == MODE_UP || (bounce && dir == UP);
  // counter only runs while staying in SCAN and restarts on every entry into SCAN
  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == SCAN && state_n == SCAN),
    .clr  (state != SCAN && state_n == SCAN),
    .tick (tick)
  );
  always_comb begin
    state_n = state;
    dir_n   = dir;
    pos_n   = pos;
    idx_n   = idx;
    hold_n  = hold;
    wrap_n  = 1'b0;
    // a request still held when the hold expires re-enters OVR with no gap
    if (state == OVR && !hold_done) hold_n = hold + 1'b1;
    else if (bus.req_valid) begin
      state_n = OVR;
      idx_n   = bus.req_idx;
      hold_n  = '0;
    end else state_n = active ? SCAN : IDLE;
    if (tick && up_step) begin
      dir_n  = (bounce && pos == 3'd7) ? DOWN : UP;
      pos_n  = (bounce && pos == 3'd7) ? 3'd6 : pos + 3'd1;
      wrap_n = pos == 3'd7;
    end else if (tick) begin
      dir_n  = (bounce && pos == 3'd0) ? UP : DOWN;
      pos_n  = (bounce && pos == 3'd0) ? 3'd1 : pos - 3'd1;
      wrap_n = pos == 3'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir        <= UP;
      pos        <= '0;
      idx        <= '0;
      hold       <= '0;
      bus.switch <= '0;
      bus.enable <= DEC_EN_OFF;
      bus.wrap   <= 1'b0;
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      pos        <= pos_n;
      idx        <= idx_n;
      hold       <= hold_n;
      bus.switch <= state_n == OVR ? idx_n : pos_n;
      bus.enable <= state_n == IDLE ? DEC_EN_OFF : DEC_EN_ON;
      bus.wrap   <= wrap_n;
    end
  end
endmodule
